// File: rtl/alu_issue_seq_pkg.sv
// Shared definitions for the alu issue sequencer: data width, opcode and
// instruction-field positions, FSM state encoding.
package alu_issue_seq_pkg;

   localparam int unsigned DSIZE = 16;

   localparam logic [3:0] OPC_LDI = 4'b1000;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 8;
   localparam int RS_MSB  = 7;
   localparam int RS_LSB  = 4;
   localparam int RT_MSB  = 3;
   localparam int RT_LSB  = 0;
   localparam int IMM8_MSB = 7;
   localparam int IMM8_LSB = 0;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRead = 2'd1,
      StExec = 2'd2,
      StWb   = 2'd3
   } seq_state_e;

   // Everything with opcode[3] set other than LDI is undefined.
   function automatic logic opc_illegal(input logic [3:0] opc);
      return opc[3] && (opc != OPC_LDI);
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// 16-entry register file: two operand read ports, one debug read port and one
// synchronous write port. Entry 0 is never written, so it always reads 0.
module alu_regfile
   import alu_issue_seq_pkg::*;
#(
   parameter int unsigned NREG = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       raddr_a,
   input  logic [3:0]       raddr_b,
   input  logic [3:0]       dbg_raddr,
   output logic [DSIZE-1:0] rdata_a,
   output logic [DSIZE-1:0] rdata_b,
   output logic [DSIZE-1:0] dbg_rdata,
   input  logic             we,
   input  logic [3:0]       waddr,
   input  logic [DSIZE-1:0] wdata
);

   logic [DSIZE-1:0] regs [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != 4'd0)) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a   = regs[raddr_a];
   assign rdata_b   = regs[raddr_b];
   assign dbg_rdata = regs[dbg_raddr];

endmodule

// File: rtl/alu_issue_seq.sv
// Issue sequencer for the combinational alu: accepts an instruction, reads
// operands, drives the alu, samples its result after ALU_WAIT cycles, writes back.
module alu_issue_seq
   import alu_issue_seq_pkg::*;
#(
   parameter int unsigned ALU_WAIT = 1,
   parameter int unsigned NREG     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid,
   input  logic [15:0]      instr_in,
   output logic             instr_ready,
   output logic [DSIZE-1:0] alu_a,
   output logic [DSIZE-1:0] alu_b,
   output logic [2:0]       alu_op,
   output logic [3:0]       alu_imm,
   input  logic [DSIZE-1:0] alu_out,
   output logic             wb_valid,
   output logic [3:0]       wb_addr,
   output logic [DSIZE-1:0] wb_data,
   output logic             err,
   input  logic [3:0]       dbg_raddr,
   output logic [DSIZE-1:0] dbg_rdata
);

   seq_state_e       state_q, state_d;
   logic [15:0]      instr_q;
   logic [3:0]       cnt_q;
   logic [DSIZE-1:0] rdata_a, rdata_b;
   logic [3:0]       opc, rd, rs, rt;
   logic             illegal, is_ldi;

   assign opc     = instr_q[OPC_MSB:OPC_LSB];
   assign rd      = instr_q[RD_MSB:RD_LSB];
   assign rs      = instr_q[RS_MSB:RS_LSB];
   assign rt      = instr_q[RT_MSB:RT_LSB];
   assign illegal = opc_illegal(opc);
   assign is_ldi  = (opc == OPC_LDI);

   alu_regfile #(
      .NREG (NREG)
   ) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .raddr_a   (rs),
      .raddr_b   (rt),
      .dbg_raddr (dbg_raddr),
      .rdata_a   (rdata_a),
      .rdata_b   (rdata_b),
      .dbg_rdata (dbg_rdata),
      .we        (wb_valid),
      .waddr     (wb_addr),
      .wdata     (wb_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (instr_valid) state_d = StRead;
         StRead: begin
            if (illegal)     state_d = StIdle;
            else if (is_ldi) state_d = StWb;
            else             state_d = StExec;
         end
         StExec: if (cnt_q == 4'd1) state_d = StWb;
         StWb:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      instr_ready = (state_q == StIdle);
      wb_valid    = (state_q == StWb);
      err         = (state_q == StRead) && illegal;
   end

   // wb_addr/wb_data double as the result register and hold until the next WB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= '0;
         cnt_q   <= '0;
         alu_a   <= '0;
         alu_b   <= '0;
         alu_op  <= '0;
         alu_imm <= '0;
         wb_addr <= '0;
         wb_data <= '0;
      end else begin
         if ((state_q == StIdle) && instr_valid) begin
            instr_q <= instr_in;
         end
         if (state_q == StRead) begin
            alu_a   <= rdata_a;
            alu_b   <= rdata_b;
            alu_op  <= opc[2:0];
            alu_imm <= rt;
            cnt_q   <= 4'(ALU_WAIT);
            if (is_ldi) begin
               wb_addr <= rd;
               wb_data <= DSIZE'(instr_q[IMM8_MSB:IMM8_LSB]);
            end
         end
         if (state_q == StExec) begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               wb_addr <= rd;
               wb_data <= alu_out;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Scoreboard bench: two sequencers (ALU_WAIT=1 and 3), each driving a
// behavioural alu; expected writebacks/errors are queued at issue time.
module tb_alu_issue_seq;
   import alu_issue_seq_pkg::*;

   typedef struct {
      int          dut;
      bit          is_err;
      logic [3:0]  addr;
      logic [15:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic [15:0] instr_in;
   int          sel;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   exp_t        sb [$];
   exp_t        mon_e;
   logic [15:0] model0 [16];

   logic             valid_v   [2];
   logic             ready     [2];
   logic [DSIZE-1:0] alu_a     [2];
   logic [DSIZE-1:0] alu_b     [2];
   logic [2:0]       alu_op    [2];
   logic [3:0]       alu_imm   [2];
   logic [DSIZE-1:0] alu_out   [2];
   logic             wb_valid  [2];
   logic [3:0]       wb_addr   [2];
   logic [DSIZE-1:0] wb_data   [2];
   logic             err       [2];
   logic [3:0]       dbg_raddr [2];
   logic [DSIZE-1:0] dbg_rdata [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic [2:0] op, input logic [3:0] imm);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a << imm;
         3'd5:    return a >> imm;
         3'd6:    return a ^ b;
         default: return a;
      endcase
   endfunction

   assign valid_v[0] = instr_valid && (sel == 0);
   assign valid_v[1] = instr_valid && (sel == 1);
   assign alu_out[0] = alu_model(alu_a[0], alu_b[0], alu_op[0], alu_imm[0]);
   assign alu_out[1] = alu_model(alu_a[1], alu_b[1], alu_op[1], alu_imm[1]);

   alu_issue_seq #(.ALU_WAIT(1), .NREG(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .instr_valid(valid_v[0]), .instr_in(instr_in),
      .instr_ready(ready[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]),
      .alu_imm(alu_imm[0]), .alu_out(alu_out[0]), .wb_valid(wb_valid[0]),
      .wb_addr(wb_addr[0]), .wb_data(wb_data[0]), .err(err[0]),
      .dbg_raddr(dbg_raddr[0]), .dbg_rdata(dbg_rdata[0])
   );

   alu_issue_seq #(.ALU_WAIT(3), .NREG(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .instr_valid(valid_v[1]), .instr_in(instr_in),
      .instr_ready(ready[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]),
      .alu_imm(alu_imm[1]), .alu_out(alu_out[1]), .wb_valid(wb_valid[1]),
      .wb_addr(wb_addr[1]), .wb_data(wb_data[1]), .err(err[1]),
      .dbg_raddr(dbg_raddr[1]), .dbg_rdata(dbg_rdata[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at a negedge; returns #1 after the handshake edge.
   task automatic issue(input int d, input logic [15:0] ins, input bit push, input bit is_err,
                        input logic [3:0] a, input logic [15:0] dat, input int lat);
      int n = 0;
      sel = d;
      instr_in = ins;
      instr_valid = 1'b1;
      while (!ready[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ready[d]) begin
         total++;
         bad++;
         $display("FAIL issue_timeout dut%0d: got ready=0 want ready=1", d);
         instr_valid = 1'b0;
         return;
      end
      if (push) sb.push_back('{dut: d, is_err: is_err, addr: a, data: dat, cyc: cyc + lat});
      @(posedge clk);
      #1 instr_valid = 1'b0;
   endtask

   task automatic wait_done(input int d);
      int n = 0;
      @(negedge clk);
      while ((sb.size() != 0 || !ready[d]) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", sb.size(), 0);
   endtask

   task automatic dbg_chk(input int d, input logic [3:0] r, input logic [15:0] exp);
      dbg_raddr[d] = r;
      #1 chk($sformatf("dbg_dut%0d_r%0d", d, r), dbg_rdata[d], exp);
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst_n && (wb_valid[d] || err[d])) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_out dut%0d: got wb=%0b err=%0b want none",
                        d, wb_valid[d], err[d]);
            end else begin
               mon_e = sb.pop_front();
               chk("out_dut", d, mon_e.dut);
               chk("out_err", err[d], mon_e.is_err);
               chk("out_wb", wb_valid[d], !mon_e.is_err);
               if (!mon_e.is_err) begin
                  chk("wb_addr", wb_addr[d], mon_e.addr);
                  chk("wb_data", wb_data[d], mon_e.data);
               end
               chk("out_cycle", cyc, mon_e.cyc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      instr_valid = 1'b0;
      instr_in = '0;
      sel = 0;
      dbg_raddr[0] = '0;
      dbg_raddr[1] = '0;
      for (int r = 0; r < 16; r++) model0[r] = '0;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_ready", ready[d], 1);
         chk("rst_alu_a", alu_a[d], 0);
         chk("rst_alu_b", alu_b[d], 0);
         chk("rst_alu_op", alu_op[d], 0);
         chk("rst_alu_imm", alu_imm[d], 0);
         chk("rst_wb_valid", wb_valid[d], 0);
         chk("rst_wb_addr", wb_addr[d], 0);
         chk("rst_wb_data", wb_data[d], 0);
         chk("rst_err", err[d], 0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // LDI R1,0x0C and LDI R2,0x33
      issue(0, 16'h810C, 1, 0, 4'd1, 16'h000C, 2);
      wait_done(0);
      model0[1] = 16'h000C;
      issue(0, 16'h8233, 1, 0, 4'd2, 16'h0033, 2);
      wait_done(0);
      model0[2] = 16'h0033;
      dbg_chk(0, 4'd1, 16'h000C);
      dbg_chk(0, 4'd2, 16'h0033);

      // add R3 = R2 + R1
      @(negedge clk);
      issue(0, 16'h0321, 1, 0, 4'd3, 16'h003F, 3);
      @(negedge clk);
      @(negedge clk);
      chk("exec_alu_a", alu_a[0], 16'h0033);
      chk("exec_alu_b", alu_b[0], 16'h000C);
      chk("exec_alu_op", alu_op[0], 0);
      wait_done(0);
      model0[3] = 16'h003F;
      dbg_chk(0, 4'd3, 16'h003F);

      // illegal opcode 0xA
      @(negedge clk);
      issue(0, 16'hA123, 1, 1, 4'd0, 16'h0000, 1);
      @(negedge clk);
      chk("illegal_ready_c1", ready[0], 0);
      @(negedge clk);
      chk("illegal_ready_c2", ready[0], 1);
      wait_done(0);
      for (int r = 1; r < 16; r++) dbg_chk(0, 4'(r), model0[r]);

      // LDI R0,0xFF: strobe fires, R0 stays 0
      @(negedge clk);
      issue(0, 16'h80FF, 1, 0, 4'd0, 16'h00FF, 2);
      wait_done(0);
      dbg_chk(0, 4'd0, 16'h0000);

      // reset during EXEC aborts the instruction
      @(negedge clk);
      issue(0, 16'h0421, 0, 0, 4'd4, 16'h0000, 3);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_ready", ready[0], 1);
      chk("abort_alu_a", alu_a[0], 0);
      chk("abort_alu_b", alu_b[0], 0);
      chk("abort_wb_addr", wb_addr[0], 0);
      chk("abort_wb_data", wb_data[0], 0);
      chk("abort_wb_valid", wb_valid[0], 0);
      for (int r = 0; r < 16; r++) dbg_chk(0, 4'(r), 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);

      // ALU_WAIT=3: LDI R1,0x0C then shl R5 = R1 << 4
      issue(1, 16'h810C, 1, 0, 4'd1, 16'h000C, 2);
      wait_done(1);
      @(negedge clk);
      issue(1, 16'h4514, 1, 0, 4'd5, 16'h00C0, 5);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("exec3_alu_a", alu_a[1], 16'h000C);
         chk("exec3_alu_b", alu_b[1], 16'h0000);
         chk("exec3_alu_op", alu_op[1], 4);
         chk("exec3_alu_imm", alu_imm[1], 4);
      end
      wait_done(1);
      dbg_chk(1, 4'd5, 16'h00C0);

      repeat (4) @(negedge clk);
      chk("final_queue_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Sequencing initiator for the combinational `alu` datapath block; it is the driving side of the alu operand/op/imm interface.
- Accepts 16-bit instructions over a valid/ready handshake and decodes them.
- Reads operands from an internal 16x`DSIZE` register file and presents `A`, `B`, `op` and `imm` to the alu.
- Samples the alu result after a fixed settle time and writes it back, with a writeback strobe for observation.

Parameters:
ALU_WAIT, 1, cycles EXEC holds alu inputs stable before sampling alu_out (legal 1..15)
NREG, 16, register count; register index width is 4, fixed

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_in  in  16  [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt or imm
instr_ready  out  1  sequencer can accept an instruction
alu_a  out  `DSIZE  operand A to alu
alu_b  out  `DSIZE  operand B to alu
alu_op  out  3  alu op select
alu_imm  out  4  alu immediate / shift amount
alu_out  in  `DSIZE  alu result (combinational from the alu_* outputs)
wb_valid  out  1  one-cycle writeback strobe
wb_addr  out  4  writeback register index
wb_data  out  `DSIZE  writeback value
err  out  1  one-cycle illegal-opcode strobe
dbg_raddr  in  4  debug register read index
dbg_rdata  out  `DSIZE  combinational register-file read at dbg_raddr

Behaviour:
- Reset (async, rst_n=0):
  - FSM enters IDLE.
  - All registers cleared to 0.
  - instr_ready=1; alu_a, alu_b, alu_op, alu_imm, wb_valid, wb_addr, wb_data and err all 0.
- Reset asserted mid-operation aborts the instruction: no wb_valid, no err, and the register file is cleared.
- Decode:
  - opcode[3]=0 is an ALU op: alu_op=opcode[2:0], alu_imm=instr[3:0], alu_a=R[rs], alu_b=R[rt].
  - opcode 4'b1000 is LDI: result = zero-extended instr[7:0]; the alu is not used.
  - Opcodes 9..15 are illegal.
- R0 reads as 0. Writes to R0 are discarded, but wb_valid still pulses with wb_addr=0 and the computed wb_data.
- FSM states:
  - IDLE:
    - instr_ready=1.
    - On instr_valid&instr_ready, latch instr_in and go to READ.
    - instr_valid while not ready is ignored; the source holds it.
  - READ:
    - instr_ready=0.
    - Register alu_a, alu_b, alu_op and alu_imm from the register file.
    - If illegal: pulse err for this cycle and go to IDLE; no writeback, registers unchanged.
    - If LDI: go to WB directly.
    - Otherwise load the wait counter with ALU_WAIT and go to EXEC.
  - EXEC:
    - alu_* outputs are held constant.
    - The counter decrements each cycle.
    - When the counter reaches 1, capture alu_out into the result register and go to WB.
  - WB:
    - Write R[rd] (unless rd=0) and pulse wb_valid=1 with wb_addr=rd and wb_data=result.
    - Go to IDLE. instr_ready returns to 1 in the cycle after WB.
- Latency, with handshake at edge 0:
  - ALU op: wb_valid high in cycle 2+ALU_WAIT.
  - LDI: wb_valid high in cycle 2.
  - Illegal: err high in cycle 1.
- Throughput: one instruction in flight. Back-to-back instructions see the previous writeback, so no forwarding is required.
- alu_* outputs hold their last value outside EXEC. They are not cleared.
- wb_data and wb_addr hold until the next WB. wb_valid and err are single-cycle.
- dbg_rdata:
  - Reflects the register-file contents before any same-cycle write (old value during WB).
  - dbg_raddr=0 returns 0.
- Width: all data is `DSIZE` bits. alu_out is taken verbatim; no overflow flag.

Decomposition:
- Shared package/include (`define.v`) holds:
  - `DSIZE`.
  - Opcode constants: OPC_LDI=4'b1000; ALU ops 0..7 taken from alu op encoding.
  - Instruction field position macros.
  - FSM state encodings: IDLE=2'd0, READ=2'd1, EXEC=2'd2, WB=2'd3.
- One sub-module: `alu_regfile`.
  - Contents: 16x`DSIZE`, two combinational read ports plus a debug read port, one synchronous write port, R0 hardwired to 0, async active-low clear.
- Bench instantiates `alu_issue_seq` with the existing `alu` connected on alu_a, alu_b, alu_op, alu_imm and alu_out.

Test Plan:
- LDI R1,0x0C then LDI R2,0x33 -> wb_valid at cycle 2 of each with wb_addr 1/2 and wb_data 000C/0033; dbg_raddr=1 reads 000C afterwards.
- After the LDIs, issue op0 rd=3 rs=2 rt=1 with ALU_WAIT=1 -> alu_a=0033, alu_b=000C, alu_op=0 during EXEC; wb_valid at cycle 3 with wb_data equal to the alu add result (003F) and R3=003F.
- Opcode 4'hA with instr_valid held -> err pulses at cycle 1, no wb_valid, R1..R15 unchanged, instr_ready back to 1 at cycle 2.
- LDI R0,0xFF -> wb_valid=1, wb_addr=0, wb_data=00FF; dbg_raddr=0 still reads 0000.
- ALU_WAIT=3, then op4 rd=5 rs=1 imm=4 -> alu_* stable for 3 EXEC cycles; wb_valid at cycle 5 carrying the alu result.
- Deassert rst_n during EXEC of an ALU op -> outputs 0 immediately, instr_ready=1, no wb_valid afterwards, all dbg reads 0000.
